// File: rtl/vc_out_sched_if.sv
// ============================================================================
// vc_out_sched_if : flit/credit bundle between per-VC buffers, scheduler, link
// Rev 1.0
// ============================================================================
`default_nettype none

interface vc_out_sched_if #(
  parameter int NVC   = 4,
  parameter int DATAW = 64,
  parameter int PORTW = 3
);
  localparam int VCW = $clog2(NVC);

  logic [NVC-1:0]       req;
  logic [NVC-1:0]       tail;
  logic [NVC*DATAW-1:0] idata;
  logic [NVC*PORTW-1:0] iport;
  logic [NVC-1:0]       credit_in;
  logic [NVC-1:0]       ack;
  logic                 ovalid;
  logic [DATAW-1:0]     odata;
  logic [VCW-1:0]       ovch;
  logic [PORTW-1:0]     oport;
  logic                 busy;
  logic                 cred_err;

  modport master (
    output req, tail, idata, iport, credit_in,
    input  ack, ovalid, odata, ovch, oport, busy, cred_err
  );

  modport slave (
    input  req, tail, idata, iport, credit_in,
    output ack, ovalid, odata, ovch, oport, busy, cred_err
  );
endinterface

`default_nettype wire

// File: rtl/vc_out_sched.sv
// ============================================================================
// vc_out_sched : round-robin VC scheduler with wormhole lock and per-VC credits
// Rev 1.0
// ============================================================================
`default_nettype none

module vc_out_sched #(
  parameter int NVC     = 4,
  parameter int DATAW   = 64,
  parameter int PORTW   = 3,
  parameter int CREDITS = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_,
  vc_out_sched_if.slave   bus
);
  localparam int VCW = $clog2(NVC);
  localparam int CW  = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [VCW-1:0]   rr_q, rr_d;
  logic [VCW-1:0]   holder_q, holder_d;
  logic [CW-1:0]    cred_q [NVC];
  logic             cred_err_q;
  logic             ovalid_q;
  logic [DATAW-1:0] odata_q;
  logic [VCW-1:0]   ovch_q;
  logic [PORTW-1:0] oport_q;

  logic [NVC-1:0]   elig;
  logic [NVC-1:0]   ack_w;
  logic [NVC-1:0]   ovf_w;
  logic             found;
  logic [VCW-1:0]   win;
  logic [VCW-1:0]   cand;
  logic             sel_vld;
  logic [VCW-1:0]   sel_idx;

  function automatic logic [VCW-1:0] next_vc(input logic [VCW-1:0] v);
    return (int'(v) == NVC - 1) ? '0 : v + VCW'(1);
  endfunction

  // Scan starts at rr_ptr so the VC after the last packet owner has priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NVC; k++) begin
      cand = VCW'((int'(rr_q) + k) % NVC);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    holder_d = holder_q;
    sel_vld  = 1'b0;
    sel_idx  = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          sel_vld = 1'b1;
          sel_idx = win;
          if (bus.tail[win]) begin
            rr_d = next_vc(win);
          end else begin
            state_d  = S_LOCKED;
            holder_d = win;
          end
        end
      end
      S_LOCKED: begin
        if (elig[holder_q]) begin
          sel_vld = 1'b1;
          sel_idx = holder_q;
          if (bus.tail[holder_q]) begin
            state_d = S_IDLE;
            rr_d    = next_vc(holder_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    ack_w = '0;
    if (sel_vld && rst_) ack_w[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      holder_q   <= '0;
      ovalid_q   <= 1'b0;
      odata_q    <= '0;
      ovch_q     <= '0;
      oport_q    <= '0;
      cred_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      holder_q   <= holder_d;
      ovalid_q   <= sel_vld;
      odata_q    <= sel_vld ? bus.idata[int'(sel_idx)*DATAW +: DATAW] : '0;
      ovch_q     <= sel_vld ? sel_idx : '0;
      oport_q    <= sel_vld ? bus.iport[int'(sel_idx)*PORTW +: PORTW] : '0;
      cred_err_q <= cred_err_q | (|ovf_w);
    end
  end

  // Simultaneous send and return cancel; a return into a full counter is an error.
  for (genvar i = 0; i < NVC; i++) begin : g_cred
    assign elig[i]  = bus.req[i] & (cred_q[i] != '0);
    assign ovf_w[i] = bus.credit_in[i] & ~ack_w[i] & (cred_q[i] == CRED_MAX);

    always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
        cred_q[i] <= CRED_MAX;
      end else if (ack_w[i] && !bus.credit_in[i]) begin
        cred_q[i] <= cred_q[i] - CW'(1);
      end else if (bus.credit_in[i] && !ack_w[i] && (cred_q[i] != CRED_MAX)) begin
        cred_q[i] <= cred_q[i] + CW'(1);
      end
    end
  end

  assign bus.ack      = ack_w;
  assign bus.ovalid   = ovalid_q;
  assign bus.odata    = odata_q;
  assign bus.ovch     = ovch_q;
  assign bus.oport    = oport_q;
  assign bus.busy     = (state_q == S_LOCKED);
  assign bus.cred_err = cred_err_q;

endmodule

`default_nettype wire

// File: tb/tb_vc_out_sched.sv
// ============================================================================
// tb_vc_out_sched : directed checks of arbitration, lock, credits and reset
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vc_out_sched;
  localparam int NVC   = 4;
  localparam int DATAW = 16;
  localparam int PORTW = 3;

  logic clk;
  logic rst_;
  int   n_tests;
  int   n_fail;

  vc_out_sched_if #(.NVC(NVC), .DATAW(DATAW), .PORTW(PORTW)) bus ();

  vc_out_sched #(
    .NVC(NVC), .DATAW(DATAW), .PORTW(PORTW), .CREDITS(4)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATAW-1:0] dat(input int i);
    return 16'hA000 + 16'(i * 16'h0111);
  endfunction

  function automatic logic [PORTW-1:0] prt(input int i);
    return 3'((i + 5) % 8);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit v, input int vc);
    chk({tag, "_ovalid"}, 64'(bus.ovalid), 64'(v));
    chk({tag, "_ovch"},   64'(bus.ovch),   v ? 64'(vc) : 64'd0);
    chk({tag, "_odata"},  64'(bus.odata),  v ? 64'(dat(vc)) : 64'd0);
    chk({tag, "_oport"},  64'(bus.oport),  v ? 64'(prt(vc)) : 64'd0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_          = 1'b0;
    bus.req       = 4'b1111;
    bus.tail      = 4'b1111;
    bus.credit_in = 4'b0000;
    for (int i = 0; i < NVC; i++) begin
      bus.idata[i*DATAW +: DATAW] = dat(i);
      bus.iport[i*PORTW +: PORTW] = prt(i);
    end

    // reset / idle
    #12;
    chk("rst_ack", 64'(bus.ack), 64'd0);
    chk_out("rst", 1'b0, 0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_err", 64'(bus.cred_err), 64'd0);
    bus.req  = 4'b0000;
    bus.tail = 4'b0000;
    #1 rst_ = 1'b1;
    tick;
    chk("idle_ack", 64'(bus.ack), 64'd0);
    chk_out("idle", 1'b0, 0);
    chk("idle_busy", 64'(bus.busy), 64'd0);

    // round robin, single-flit packets, credit returned alongside each ack
    for (int k = 0; k < 6; k++) begin
      bus.req       = 4'b1111;
      bus.tail      = 4'b1111;
      bus.credit_in = 4'(1 << (k % 4));
      #1 chk("rr_ack", 64'(bus.ack), 64'(1 << (k % 4)));
      tick;
      chk_out("rr", 1'b1, k % 4);
    end
    bus.credit_in = 4'b0000;

    // wormhole: VC2 holds for 3 flits, then VC3 wins
    bus.tail = 4'b0000;
    #1 chk("wh_ack1", 64'(bus.ack), 64'b0100);
    tick;
    chk_out("wh1", 1'b1, 2);
    chk("wh_busy1", 64'(bus.busy), 64'd1);
    #1 chk("wh_ack2", 64'(bus.ack), 64'b0100);
    tick;
    chk_out("wh2", 1'b1, 2);
    chk("wh_busy2", 64'(bus.busy), 64'd1);
    bus.tail = 4'b0100;
    #1 chk("wh_ack3", 64'(bus.ack), 64'b0100);
    tick;
    chk_out("wh3", 1'b1, 2);
    chk("wh_busy3", 64'(bus.busy), 64'd0);
    bus.tail = 4'b1000;
    #1 chk("wh_next", 64'(bus.ack), 64'b1000);
    tick;
    chk_out("wh4", 1'b1, 3);
    bus.req  = 4'b0000;
    bus.tail = 4'b0000;
    #1 chk("wh_quiet", 64'(bus.ack), 64'd0);
    tick;
    chk_out("wh_quiet", 1'b0, 0);

    // credit stall: VC1 six-flit packet, four credits
    bus.req = 4'b0010;
    for (int f = 0; f < 4; f++) begin
      #1 chk("st_ack", 64'(bus.ack), 64'b0010);
      tick;
      chk_out("st", 1'b1, 1);
      chk("st_busy", 64'(bus.busy), 64'd1);
    end
    #1 chk("st_stall_ack", 64'(bus.ack), 64'd0);
    tick;
    chk_out("st_stall", 1'b0, 0);
    chk("st_stall_busy", 64'(bus.busy), 64'd1);
    bus.credit_in = 4'b0010;
    #1 chk("st_cred_same", 64'(bus.ack), 64'd0);
    tick;
    bus.credit_in = 4'b0000;
    #1 chk("st_cred_next", 64'(bus.ack), 64'b0010);
    tick;
    chk_out("st5", 1'b1, 1);
    bus.credit_in = 4'b0010;
    tick;
    bus.credit_in = 4'b0000;
    bus.tail      = 4'b0010;
    #1 chk("st_tail_ack", 64'(bus.ack), 64'b0010);
    tick;
    chk_out("st6", 1'b1, 1);
    chk("st_done_busy", 64'(bus.busy), 64'd0);
    bus.req  = 4'b0000;
    bus.tail = 4'b0000;

    // ack and credit_in together keep VC0 at four credits
    bus.req  = 4'b0001;
    bus.tail = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      bus.credit_in = 4'b0001;
      #1 chk("sim_ack", 64'(bus.ack), 64'b0001);
      tick;
      chk_out("sim", 1'b1, 0);
    end
    bus.credit_in = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      #1 chk("sim_drain", 64'(bus.ack), (k < 4) ? 64'b0001 : 64'd0);
      tick;
    end
    bus.req  = 4'b0000;
    bus.tail = 4'b0000;

    // overflow: VC3 refilled to 4, then one extra return
    bus.credit_in = 4'b1000;
    tick;
    bus.credit_in = 4'b0000;
    #1 chk("ovf_before", 64'(bus.cred_err), 64'd0);
    bus.credit_in = 4'b1000;
    tick;
    bus.credit_in = 4'b0000;
    #1 chk("ovf_set", 64'(bus.cred_err), 64'd1);
    tick;
    chk("ovf_sticky", 64'(bus.cred_err), 64'd1);
    bus.req  = 4'b1000;
    bus.tail = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      #1 chk("ovf_drain", 64'(bus.ack), (k < 4) ? 64'b1000 : 64'd0);
      tick;
    end
    bus.req  = 4'b0000;
    bus.tail = 4'b0000;

    // async reset in the middle of a locked VC2 packet
    bus.req = 4'b0100;
    #1 chk("ar_ack", 64'(bus.ack), 64'b0100);
    tick;
    chk("ar_busy", 64'(bus.busy), 64'd1);
    chk_out("ar", 1'b1, 2);
    bus.req = 4'b1111;
    #1 chk("ar_hold", 64'(bus.ack), 64'd0);
    rst_ = 1'b0;
    #1;
    chk("ar_busy_rst", 64'(bus.busy), 64'd0);
    chk("ar_ovalid_rst", 64'(bus.ovalid), 64'd0);
    chk("ar_ack_rst", 64'(bus.ack), 64'd0);
    chk("ar_err_rst", 64'(bus.cred_err), 64'd0);
    #1 rst_ = 1'b1;
    bus.tail = 4'b1111;
    #1 chk("ar_restart", 64'(bus.ack), 64'b0001);
    tick;
    chk_out("ar_out", 1'b1, 0);
    #1 chk("ar_second", 64'(bus.ack), 64'b0010);
    tick;
    chk_out("ar_out2", 1'b1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vc_out_sched.md
# vc_out_sched

Output-port virtual-channel scheduler for the router datapath: it picks one of NVC input virtual channels per cycle and drives a single registered output flit stream (valid, data, VC id, port). It replaces the single-VC select/hold path with a multi-VC version. Selection is round-robin, packets are held (wormhole lock) from head to tail, and each downstream VC has its own credit counter. It sits between the per-VC input buffers (which pop on `ack`) and the output link/crossbar input.

## Interface
Parameters:
- NVC, 4: number of virtual channels (≥2); VCW = clog2(NVC)
- DATAW, 64: flit data width
- PORTW, 3: output-port field width
- CREDITS, 4: downstream buffer depth per VC; CW = clog2(CREDITS+1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_  in  1  reset, asynchronous, active-low
- req  in  NVC  VC i has a flit at buffer head
- tail  in  NVC  flit at head of VC i is a packet tail (head+tail = single-flit packet)
- idata  in  NVC*DATAW  head flit of VC i at bits [i*DATAW +: DATAW]
- iport  in  NVC*PORTW  routed output port of VC i
- credit_in  in  NVC  one-cycle pulse: downstream freed one slot of VC i
- ack  out  NVC  one-hot combinational pop strobe to VC i buffer
- ovalid  out  1  registered output flit valid
- odata  out  DATAW  registered flit data
- ovch  out  VCW  registered VC index of output flit
- oport  out  PORTW  registered port of output flit
- busy  out  1  packet lock held
- cred_err  out  1  sticky: credit_in received while counter full

## Operation
- Eligibility: elig[i] = req[i] & (cred[i] != 0).
- State machine, one lock for the whole output:
  - IDLE: if any elig, winner = first eligible VC scanning rr_ptr, rr_ptr+1, … mod NVC. Assert ack[winner]. If tail[winner] = 0, go to LOCKED with holder = winner. If tail[winner] = 1, stay IDLE and set rr_ptr = winner+1 mod NVC.
  - LOCKED: only the holder may send. If elig[holder], assert ack[holder]. If that flit has tail = 1, go to IDLE and set rr_ptr = holder+1 mod NVC. If the holder is not eligible (no flit or no credit), ack = 0, ovalid = 0 next cycle, and the lock is kept. Other VCs are never granted while LOCKED.
- At most one ack bit is set per cycle. ack is zero when nothing is eligible.
- Output register: on an edge where ack[i] = 1, load odata = idata[i], ovch = i, oport = iport[i], ovalid = 1. Otherwise ovalid = 0; odata, ovch and oport are cleared to 0.
- Credits, per VC:
  - ack[i] only: cred[i] decrements by 1.
  - credit_in[i] only: cred[i] increments by 1.
  - Both in the same cycle: cred[i] unchanged.
  - credit_in[i] alone with cred[i] = CREDITS: counter stays at CREDITS and cred_err is set.
  - Counter never underflows, because ack requires cred ≠ 0.
- busy = (state == LOCKED).
- cred_err stays set until reset.
- Reset (async assert, any time, including mid-packet):
  - state IDLE, rr_ptr 0, holder 0, every cred = CREDITS
  - ovalid 0, odata 0, ovch 0, oport 0, busy 0, cred_err 0
  - ack is 0 while rst_ is low
  - a partially sent packet is abandoned; recovering the buffers is upstream's job.

## Timing
- ack is combinational, same cycle as req/tail/credit.
- The flit appears on odata/ovalid one cycle after its ack (latency 1).
- Throughput: 1 flit/cycle sustained when the winner stays eligible.
- No idle cycle is inserted at packet boundaries: a tail in cycle t lets a new winner be acked in cycle t+1.
- A credit_in in cycle t is usable for ack in cycle t+1, not in cycle t.
- With CREDITS = 4 and no credit return, a VC sends 4 flits and then stalls.
- rr_ptr and the lock update only on acked flits. Requests that drop without being acked do not move the pointer.

## Test plan
- Reset/idle: rst_ low, then high with req = 0. Required: ack = 0, ovalid = 0, busy = 0, every cred = 4, cred_err = 0.
- Round-robin with single-flit packets: req = 4'b1111, tail = 4'b1111, credits returned each cycle. Required: ack sequence VC0, 1, 2, 3, 0, …; ovch on the output follows one cycle later.
- Wormhole lock: VC2 sends a 3-flit packet (tail on the third flit) while VC0, VC1 and VC3 all request. Required: ack[2] for 3 consecutive cycles with busy = 1, then ack[3] in the next cycle.
- Credit stall: VC1 alone, a 6-flit packet, no credit_in. Required: 4 flits out; ovalid = 0 from the 5th cycle on; busy stays 1. A credit_in[1] pulse at cycle t gives ack[1] at t+1.
- Simultaneous events and error:
  - ack[0] and credit_in[0] in the same cycle: cred[0] unchanged.
  - credit_in[3] with cred[3] = 4: cred[3] stays 4 and cred_err = 1 from the next cycle on.
- Async reset mid-packet: drop rst_ between clock edges during a locked packet. Required: busy, ovalid and ack go to 0 immediately. After release, arbitration restarts at VC0.
